dna_reader: RTL and testbench

DNA_READER -- requirements
Module: dna_reader

---
 rtl/dna_reader_pkg.sv | 36 +++
 rtl/dna_reader_if.sv | 23 ++
 rtl/dna_bus_driver.sv | 18 +
 rtl/dna_reader.sv | 153 +++++++++++++++
 tb/tb_dna_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dna_reader_pkg.sv
// Shared definitions for the DNA reader: RAM instruction encodings, global phase
// values, reader FSM states and the network geometry helper functions.
package dna_reader_pkg;

    localparam logic INSTR_READ  = 1'b0;
    localparam logic INSTR_WRITE = 1'b1;

    // Global phase carried on networkState; the reader owns the RAM bus in PHASE_DNA_READ.
    typedef enum logic [1:0] {
        PHASE_IDLE     = 2'd0,
        PHASE_DNA_READ = 2'd1,
        PHASE_EVALUATE = 2'd2,
        PHASE_EVOLVE   = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_BUSY,
        ST_WAIT_DATA,
        ST_PRESENT,
        ST_DONE
    } state_e;

    localparam int ADDR_W = 23;

    function automatic int genes_per_network(input int outputs, input int neurons,
                                             input int connections);
        return outputs + neurons * connections;
    endfunction

    function automatic int gene_limit(input int outputs, input int neurons);
        return outputs + neurons + 1;
    endfunction

endpackage

// File: rtl/dna_reader_if.sv
// Consumer-side handshake bundle of the DNA reader (phase, start request, gene stream, status).
interface dna_reader_if;
    logic [1:0]  networkState;
    logic        start;
    logic [7:0]  networkIndex;
    logic [15:0] gene;
    logic        geneValid;
    logic        geneReady;
    logic [15:0] geneIndex;
    logic        busy;
    logic        done;
    logic        rangeError;

    modport master (
        output networkState, start, networkIndex, geneReady,
        input  gene, geneValid, geneIndex, busy, done, rangeError
    );

    modport slave (
        input  networkState, start, networkIndex, geneReady,
        output gene, geneValid, geneIndex, busy, done, rangeError
    );
endinterface

// File: rtl/dna_bus_driver.sv
// Tri-state gating of the shared RAM address/strobe/instruction nets: driven only while
// the reader owns the bus, released combinationally otherwise.
module dna_bus_driver
    import dna_reader_pkg::*;
(
    input  logic              own,
    input  logic [ADDR_W-1:0] addr,
    input  logic              latch,
    output wire  [23:1]       ram_bus_addr,
    output wire               ram_latch,
    output wire               ram_instruction
);

    assign ram_bus_addr    = own ? addr       : {ADDR_W{1'bz}};
    assign ram_latch       = own ? latch      : 1'bz;
    assign ram_instruction = own ? INSTR_READ : 1'bz;

endmodule

// File: rtl/dna_reader.sv
// Reads one network's genes word by word from the shared RAM and streams them out with a
// valid/ready handshake. Optional DNA_READER_RANGE_CHECK_EN folds out-of-range genes.
module dna_reader
    import dna_reader_pkg::*;
#(
    parameter int INPUT_COUNT             = 1,
    parameter int OUTPUT_COUNT            = 1,
    parameter int NEURON_COUNT            = 2,
    parameter int CONNECTIONS             = 2,
    parameter int NETWORKS_PER_POPULATION = 16,
    parameter int OWNER_STATE             = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    dna_reader_if.slave  bus,
    inout  wire  [15:0]  ramBusDataIn,
    inout  wire  [23:1]  ramBusAddr,
    inout  wire          ramLatch,
    input  logic         ramReady,
    inout  wire          ramInstruction
);

    localparam int GPN = genes_per_network(OUTPUT_COUNT, NEURON_COUNT, CONNECTIONS);
    localparam int GL  = gene_limit(OUTPUT_COUNT, NEURON_COUNT);
    localparam logic [ADDR_W-1:0] GPN_A      = ADDR_W'(GPN);
    localparam logic [15:0]       LAST_INDEX = 16'(GPN - 1);
    localparam logic [15:0]       GL_W       = 16'(GL);

    // Input count does not affect gene layout; kept only as a network descriptor.
    wire unused_input_count = (INPUT_COUNT > 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       gene_q, gene_d;
    logic [15:0]       gene_index_q, gene_index_d;
    logic              gene_valid_q, gene_valid_d;
    logic              latch_q, latch_d;
    logic              range_error_q, range_error_d;

    logic              own;
    logic              start_ok;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       captured;
    logic              captured_bad;

    assign own       = (bus.networkState == 2'(OWNER_STATE));
    assign start_ok  = bus.start && own &&
                       ({24'd0, bus.networkIndex} < NETWORKS_PER_POPULATION);
    assign base_addr = ADDR_W'(bus.networkIndex) * GPN_A;

`ifdef DNA_READER_RANGE_CHECK_EN
    assign captured_bad = (ramBusDataIn >= GL_W);
    assign captured     = captured_bad ? (ramBusDataIn % GL_W) : ramBusDataIn;
`else
    assign captured_bad = 1'b0;
    assign captured     = ramBusDataIn;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        gene_d        = gene_q;
        gene_index_d  = gene_index_q;
        gene_valid_d  = gene_valid_q;
        latch_d       = 1'b0;
        range_error_d = range_error_q;

        // Losing bus ownership abandons the read without a done pulse.
        if (state_q != ST_IDLE && !own) begin
            state_d      = ST_IDLE;
            gene_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        addr_d        = base_addr;
                        gene_index_d  = 16'd0;
                        range_error_d = 1'b0;
                        state_d       = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ramReady) begin
                        latch_d = 1'b1;
                        state_d = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!ramReady) state_d = ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (ramReady) begin
                        gene_d        = captured;
                        gene_valid_d  = 1'b1;
                        range_error_d = range_error_q | captured_bad;
                        state_d       = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.geneReady && gene_valid_q) begin
                        gene_valid_d = 1'b0;
                        if (gene_index_q == LAST_INDEX) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d       = addr_q + 1'b1;
                            gene_index_d = gene_index_q + 16'd1;
                            state_d      = ST_REQ;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            gene_q        <= '0;
            gene_index_q  <= '0;
            gene_valid_q  <= 1'b0;
            latch_q       <= 1'b0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            gene_q        <= gene_d;
            gene_index_q  <= gene_index_d;
            gene_valid_q  <= gene_valid_d;
            latch_q       <= latch_d;
            range_error_q <= range_error_d;
        end
    end

    assign bus.gene       = gene_q;
    assign bus.geneValid  = gene_valid_q;
    assign bus.geneIndex  = gene_index_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.rangeError = range_error_q;

    dna_bus_driver u_bus_driver (
        .own             (own),
        .addr            (addr_q),
        .latch           (latch_q),
        .ram_bus_addr    (ramBusAddr),
        .ram_latch       (ramLatch),
        .ram_instruction (ramInstruction)
    );

endmodule

// File: tb/tb_dna_reader.sv
// Scoreboard bench for dna_reader: a RAM model answers with the word address, expected
// addresses/genes are queued at issue time and popped by negedge monitors.
`timescale 1ns/1ps
module tb_dna_reader;

    localparam int OUTS  = 1;
    localparam int NEUR  = 2;
    localparam int CONN  = 2;
    localparam int NETS  = 16;
    localparam int OWNER = 1;
    localparam int GPN   = OUTS + NEUR * CONN;
    localparam int GLIM  = OUTS + NEUR + 1;
`ifdef DNA_READER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dna_reader_if ifc();

    wire  [15:0] ramBusDataIn;
    wire  [23:1] ramBusAddr;
    wire         ramLatch;
    wire         ramInstruction;
    logic        ramReady = 1'b1;

    // Released nets read as latch=0 / instruction=1 (WRITE), distinct from owned READ.
    pulldown (ramLatch);
    pullup   (ramInstruction);

    logic [15:0] ram_q     = 16'd0;
    int          ram_cnt   = 0;
    int          ram_delay = 1;
    bit          force9    = 1'b0;
    bit          rand_ready = 1'b0;
    assign ramBusDataIn = ram_q;

    dna_reader #(
        .INPUT_COUNT(1), .OUTPUT_COUNT(OUTS), .NEURON_COUNT(NEUR), .CONNECTIONS(CONN),
        .NETWORKS_PER_POPULATION(NETS), .OWNER_STATE(OWNER)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (ifc),
        .ramBusDataIn   (ramBusDataIn),
        .ramBusAddr     (ramBusAddr),
        .ramLatch       (ramLatch),
        .ramReady       (ramReady),
        .ramInstruction (ramInstruction)
    );

    // RAM: on a strobe it goes busy for ram_delay cycles, then returns the word.
    always @(posedge clk) begin
        if (ram_cnt > 0) begin
            ram_cnt <= ram_cnt - 1;
            if (ram_cnt == 1) ramReady <= 1'b1;
        end else if (ramLatch === 1'b1) begin
            ramReady <= 1'b0;
            ram_cnt  <= ram_delay;
            ram_q    <= force9 ? 16'd9 : ramBusAddr[16:1];
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) ifc.geneReady = 1'($urandom_range(0, 1));
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_gene_q[$];
    logic [15:0] exp_idx_q[$];
    logic [22:0] exp_addr_q[$];
    int done_exp  = 0;
    int done_seen = 0;
    bit exp_range = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_gene(input logic [15:0] w);
        if (RANGE_EN && w >= 16'(GLIM)) return w % 16'(GLIM);
        return w;
    endfunction

    // Monitors: accepted genes and every owned strobe are checked against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.geneValid && ifc.geneReady) begin
                if (exp_gene_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_gene: got %0d, expected no gene", ifc.gene);
                end else begin
                    chk("gene", 32'(ifc.gene), 32'(exp_gene_q.pop_front()));
                    chk("geneIndex", 32'(ifc.geneIndex), 32'(exp_idx_q.pop_front()));
                    $display("gene accepted: index %0d value %0d", ifc.geneIndex, ifc.gene);
                end
            end
            if (ramLatch === 1'b1) begin
                chk("instruction_read", 32'(ramInstruction), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_latch: got addr %0d, expected no RAM access", ramBusAddr);
                end else begin
                    chk("latch_addr", 32'(ramBusAddr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (ifc.done) done_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: no RAM access expected, 1: first strobe only, 2: complete read
    task automatic issue(input int n, input int mode);
        logic [15:0] w;
        bit bad;
        bad = 1'b0;
        if (mode >= 1) exp_addr_q.push_back(23'(n * GPN));
        if (mode == 2) begin
            for (int k = 1; k < GPN; k++) exp_addr_q.push_back(23'(n * GPN + k));
            for (int k = 0; k < GPN; k++) begin
                w = force9 ? 16'd9 : 16'(n * GPN + k);
                exp_gene_q.push_back(exp_gene(w));
                exp_idx_q.push_back(16'(k));
                if (w >= 16'(GLIM)) bad = 1'b1;
            end
            done_exp++;
            exp_range = RANGE_EN && bad;
        end
        ifc.networkIndex = 8'(n);
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!ifc.done && t < 500) begin
            step();
            t++;
        end
        chk(name, 32'(ifc.done), 32'd1);
        chk("rangeError", 32'(ifc.rangeError), 32'(exp_range));
        step();
        chk("done_one_cycle", 32'(ifc.done), 32'd0);
        chk("busy_after_done", 32'(ifc.busy), 32'd0);
        $display("read finished: %s", name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        ifc.networkState = 2'(OWNER);
        ifc.start        = 1'b0;
        ifc.networkIndex = 8'd0;
        ifc.geneReady    = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();

        chk("reset_busy", 32'(ifc.busy), 0);
        chk("reset_geneValid", 32'(ifc.geneValid), 0);
        chk("reset_done", 32'(ifc.done), 0);
        chk("reset_gene", 32'(ifc.gene), 0);
        chk("reset_geneIndex", 32'(ifc.geneIndex), 0);
        chk("reset_rangeError", 32'(ifc.rangeError), 0);
        chk("reset_latch", 32'(ramLatch), 0);
        chk("reset_instruction", 32'(ramInstruction), 0);
        rst_n = 1'b1;
        step();

        // Network 3: addresses 15..19, minimum latency with an immediate RAM.
        ifc.geneReady = 1'b1;
        issue(3, 2);
        lat = 0;
        while (!ifc.geneValid && lat < 50) begin
            step();
            lat++;
        end
        chk("first_gene_latency", 32'(lat), 32'd4);
        wait_done("net3_done");

        // Random networks with random consumer backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            issue(int'($urandom_range(0, NETS - 1)), 2);
            wait_done("random_done");
            repeat ($urandom_range(0, 3)) step();
        end
        rand_ready = 1'b0;
        ifc.geneReady = 1'b0;
        step();

        // Consumer stalls 10 cycles in PRESENT.
        issue(7, 2);
        lat = 0;
        while (!ifc.geneValid && lat < 50) begin
            step();
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_valid", 32'(ifc.geneValid), 1);
            chk("stall_gene", 32'(ifc.gene), 32'(exp_gene(16'(7 * GPN))));
            chk("stall_index", 32'(ifc.geneIndex), 0);
            chk("stall_no_latch", 32'(ramLatch), 0);
        end
        ifc.geneReady = 1'b1;
        wait_done("stall_done");

        // Start while busy is dropped.
        issue(5, 2);
        step();
        ifc.networkIndex = 8'd9;
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        chk("busy_during_read", 32'(ifc.busy), 1);
        wait_done("busy_start_done");
        repeat (10) step();
        chk("no_queued_read", 32'(ifc.busy), 0);

        // Out-of-range index and non-owner start are ignored.
        issue(16, 0);
        repeat (3) step();
        chk("idx16_ignored", 32'(ifc.busy), 0);
        ifc.networkState = 2'd0;
        issue(2, 0);
        chk("nonowner_ignored", 32'(ifc.busy), 0);
        chk("nonowner_released", 32'(ramInstruction), 1);
        ifc.networkState = 2'(OWNER);
        step();

        // Ownership lost during WAIT_BUSY.
        issue(2, 0);
        step();
        chk("latch_in_wait_busy", 32'(ramLatch), 1);
        ifc.networkState = 2'd0;
        #1;
        chk("abort_released_instr", 32'(ramInstruction), 1);
        chk("abort_released_latch", 32'(ramLatch), 0);
        step();
        chk("abort_busy", 32'(ifc.busy), 0);
        chk("abort_valid", 32'(ifc.geneValid), 0);
        chk("abort_done", 32'(ifc.done), 0);
        ifc.networkState = 2'(OWNER);
        repeat (3) step();

        // Reset while waiting on slow RAM data.
        ram_delay = 4;
        issue(4, 1);
        step();
        step();
        step();
        rst_n = 1'b0;
        ifc.networkState = 2'd0;
        step();
        chk("midreset_busy", 32'(ifc.busy), 0);
        chk("midreset_valid", 32'(ifc.geneValid), 0);
        chk("midreset_done", 32'(ifc.done), 0);
        chk("midreset_gene", 32'(ifc.gene), 0);
        chk("midreset_index", 32'(ifc.geneIndex), 0);
        chk("midreset_rangeError", 32'(ifc.rangeError), 0);
        chk("midreset_released", 32'(ramInstruction), 1);
        rst_n = 1'b1;
        ifc.networkState = 2'(OWNER);
        repeat (8) step();
        chk("midreset_stays_idle", 32'(ifc.geneValid), 0);
        ram_delay = 1;

        // RAM word 9 against GENE_LIMIT 4.
        force9 = 1'b1;
        issue(0, 2);
        wait_done("force9_done");
        force9 = 1'b0;
        step();

        chk("done_pulses", 32'(done_seen), 32'(done_exp));
        chk("genes_left", 32'(exp_gene_q.size()), 0);
        chk("addrs_left", 32'(exp_addr_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
